// File: rtl/aes_job_sched.sv
// aes_job_sched
//   Queues complete AES-CTR jobs written by the host and programs them into the
//   stream engine one at a time, polling the engine's remaining-word register
//   until it reads zero.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   host_req_*               host soft-register request (write staging / push / abort, status read)
//   host_resp_valid/_data    host read response, one cycle after the request
//   aes_req_*                engine soft-register request, registered one-cycle strobe
//   aes_resp_valid/_data     engine read response (remaining words)
//   job_done                 one-cycle pulse per completed job
module aes_job_sched #(
    parameter int LOG_DEPTH = 2,
    parameter int CREDITS   = 8,
    parameter int POLL_GAP  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        host_req_valid,
    input  logic        host_req_isWrite,
    input  logic [31:0] host_req_addr,
    input  logic [63:0] host_req_data,
    output logic        host_resp_valid,
    output logic [63:0] host_resp_data,
    output logic        aes_req_valid,
    output logic        aes_req_isWrite,
    output logic [31:0] aes_req_addr,
    output logic [63:0] aes_req_data,
    input  logic        aes_resp_valid,
    input  logic [63:0] aes_resp_data,
    output logic        job_done
);

    // state    | meaning
    // S_IDLE   | waiting for a queued job; pops the head when one is present
    // S_PROG   | writing the nine engine registers, words register last
    // S_POLL_REQ | issuing a read of the engine's remaining-word register
    // S_POLL_RSP | waiting for the poll response
    // S_GAP    | back-off between a nonzero poll response and the next poll
    // S_ABORT  | writing zero words to stop the engine
    typedef enum logic [2:0] {
        S_IDLE, S_PROG, S_POLL_REQ, S_POLL_RSP, S_GAP, S_ABORT
    } state_t;

    typedef struct packed {
        logic [255:0] key;
        logic [63:0]  src;
        logic [63:0]  dst;
        logic [33:0]  words;
    } desc_t;

    localparam int DEPTH = 1 << LOG_DEPTH;
    // The read leaves one cycle after POLL_REQ and GAP exit is one cycle before
    // POLL_REQ, so the counter is loaded two short of the idle-cycle gap.
    localparam int GAP_LOAD = (POLL_GAP >= 2) ? POLL_GAP - 2 : 0;

    logic [6:0] haddr;
    logic       host_wr, push_req, abort_req, full, push_ok, pop;

    logic [255:0]         key_q;
    logic [63:0]          src_q, dst_q;
    desc_t                queue_mem [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [LOG_DEPTH:0]   count_q;
    logic                 overflow_q;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    desc_t       job_q, job_d;
    logic [31:0] done_count_q, done_count_d;
    logic        done_pulse_q, done_pulse_d;
    logic        req_valid_q, req_valid_d;
    logic        req_wr_q, req_wr_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [63:0] req_data_q, req_data_d;
    logic        host_resp_valid_q;
    logic [63:0] host_resp_data_q;
    logic [63:0] status;

    logic unused_addr_hi;
    assign unused_addr_hi = ^host_req_addr[31:7];

    assign haddr     = host_req_addr[6:0];
    assign host_wr   = host_req_valid & host_req_isWrite;
    assign push_req  = host_wr & (haddr == 7'h30);
    assign abort_req = host_wr & (haddr == 7'h40);
    assign full      = (count_q == (LOG_DEPTH + 1)'(DEPTH));
    // Room is judged on the pre-cycle count; a same-cycle pop does not help.
    assign push_ok   = push_req & ~abort_req & ~full;
    assign pop       = (state_q == S_IDLE) & (count_q != '0) & ~abort_req;

    assign status = {done_count_q, 16'h0, 8'(count_q), 6'h0, overflow_q, state_q != S_IDLE};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q <= '0;
            src_q <= '0;
            dst_q <= '0;
        end else if (host_wr) begin
            case (haddr)
                7'h00: key_q[63:0]    <= host_req_data;
                7'h08: key_q[127:64]  <= host_req_data;
                7'h10: key_q[191:128] <= host_req_data;
                7'h18: key_q[255:192] <= host_req_data;
                7'h20: src_q          <= host_req_data;
                7'h28: dst_q          <= host_req_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            queue_mem[wr_ptr_q] <= {key_q, src_q, dst_q, host_req_data[33:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_req && full && !abort_req) begin
                overflow_q <= 1'b1;
            end
            if (abort_req) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
                case ({push_ok, pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            host_resp_valid_q <= 1'b0;
            host_resp_data_q  <= '0;
        end else begin
            host_resp_valid_q <= host_req_valid & ~host_req_isWrite;
            host_resp_data_q  <= (host_req_valid && !host_req_isWrite && haddr == 7'h38) ? status : '0;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        gap_cnt_d    = gap_cnt_q;
        job_d        = job_q;
        done_count_d = done_count_q;
        done_pulse_d = 1'b0;
        req_valid_d  = 1'b0;
        req_wr_d     = 1'b0;
        req_addr_d   = '0;
        req_data_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    job_d   = queue_mem[rd_ptr_q];
                    idx_d   = '0;
                    state_d = S_PROG;
                end
            end
            S_PROG: begin
                req_valid_d = 1'b1;
                req_wr_d    = 1'b1;
                case (idx_q)
                    4'd0: begin req_addr_d = 32'h00; req_data_d = job_q.key[63:0];    end
                    4'd1: begin req_addr_d = 32'h08; req_data_d = job_q.key[127:64];  end
                    4'd2: begin req_addr_d = 32'h10; req_data_d = job_q.key[191:128]; end
                    4'd3: begin req_addr_d = 32'h18; req_data_d = job_q.key[255:192]; end
                    4'd4: begin req_addr_d = 32'h20; req_data_d = job_q.src;          end
                    4'd5: begin req_addr_d = 32'h28; req_data_d = job_q.dst;          end
                    4'd6: begin req_addr_d = 32'h38; req_data_d = 64'(CREDITS);       end
                    4'd7: begin req_addr_d = 32'h40; req_data_d = 64'(CREDITS);       end
                    // words last: this write starts the engine
                    default: begin req_addr_d = 32'h30; req_data_d = {30'h0, job_q.words}; end
                endcase
                if (abort_req) begin
                    state_d = S_ABORT;
                end else if (idx_q == 4'd8) begin
                    state_d = S_POLL_REQ;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            S_POLL_REQ: begin
                if (abort_req) begin
                    state_d = S_ABORT;
                end else begin
                    req_valid_d = 1'b1;
                    req_addr_d  = 32'h00;
                    state_d     = S_POLL_RSP;
                end
            end
            S_POLL_RSP: begin
                if (abort_req) begin
                    state_d = S_ABORT;
                end else if (aes_resp_valid) begin
                    if (aes_resp_data == 64'h0) begin
                        done_pulse_d = 1'b1;
                        done_count_d = done_count_q + 32'd1;
                        state_d      = S_IDLE;
                    end else begin
                        gap_cnt_d = 16'(GAP_LOAD);
                        state_d   = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (abort_req) begin
                    state_d = S_ABORT;
                end else if (gap_cnt_q == '0) begin
                    state_d = S_POLL_REQ;
                end else begin
                    gap_cnt_d = gap_cnt_q - 16'd1;
                end
            end
            S_ABORT: begin
                req_valid_d = 1'b1;
                req_wr_d    = 1'b1;
                req_addr_d  = 32'h30;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            gap_cnt_q    <= '0;
            job_q        <= '0;
            done_count_q <= '0;
            done_pulse_q <= 1'b0;
            req_valid_q  <= 1'b0;
            req_wr_q     <= 1'b0;
            req_addr_q   <= '0;
            req_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            gap_cnt_q    <= gap_cnt_d;
            job_q        <= job_d;
            done_count_q <= done_count_d;
            done_pulse_q <= done_pulse_d;
            req_valid_q  <= req_valid_d;
            req_wr_q     <= req_wr_d;
            req_addr_q   <= req_addr_d;
            req_data_q   <= req_data_d;
        end
    end

    assign host_resp_valid = host_resp_valid_q;
    assign host_resp_data  = host_resp_data_q;
    assign aes_req_valid   = req_valid_q;
    assign aes_req_isWrite = req_wr_q;
    assign aes_req_addr    = req_addr_q;
    assign aes_req_data    = req_data_q;
    assign job_done        = done_pulse_q;

endmodule

// File: tb/tb_aes_job_sched.sv
// Scoreboard bench for aes_job_sched: expected engine requests and host read
// responses are queued by the stimulus and popped by a negedge monitor.
module tb_aes_job_sched;
    localparam int POLL_GAP = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        host_req_valid = 1'b0;
    logic        host_req_isWrite = 1'b0;
    logic [31:0] host_req_addr = '0;
    logic [63:0] host_req_data = '0;
    logic        host_resp_valid;
    logic [63:0] host_resp_data;
    logic        aes_req_valid;
    logic        aes_req_isWrite;
    logic [31:0] aes_req_addr;
    logic [63:0] aes_req_data;
    logic        aes_resp_valid = 1'b0;
    logic [63:0] aes_resp_data = '0;
    logic        job_done;

    always #5 clk = ~clk;

    aes_job_sched #(.LOG_DEPTH(2), .CREDITS(8), .POLL_GAP(POLL_GAP)) dut (
        .clk(clk), .rst(rst),
        .host_req_valid(host_req_valid), .host_req_isWrite(host_req_isWrite),
        .host_req_addr(host_req_addr), .host_req_data(host_req_data),
        .host_resp_valid(host_resp_valid), .host_resp_data(host_resp_data),
        .aes_req_valid(aes_req_valid), .aes_req_isWrite(aes_req_isWrite),
        .aes_req_addr(aes_req_addr), .aes_req_data(aes_req_data),
        .aes_resp_valid(aes_resp_valid), .aes_resp_data(aes_resp_data),
        .job_done(job_done)
    );

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [63:0] data;
        logic        consec;
    } req_t;

    req_t        exp_q[$];
    logic [63:0] hexp_q[$];
    logic [63:0] poll_q[$];
    req_t        mon_e;

    int errors = 0, checks = 0, cyc = 0;
    int reads_seen = 0, served = 0, done_pulses = 0;
    int prev_req_cyc = 0, nz_cyc = 0;
    bit nz_pend = 1'b0, resp_seen = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic req_t mk(input logic wr, input logic [31:0] a, input logic [63:0] d, input logic c);
        req_t r;
        r.wr = wr; r.addr = a; r.data = d; r.consec = c;
        return r;
    endfunction

    function automatic logic [255:0] mkkey(input logic [7:0] b);
        return {32'hC0DE_0004, 24'h0, b, 32'hC0DE_0003, 24'h0, b,
                32'hC0DE_0002, 24'h0, b, 32'hC0DE_0001, 24'h0, b};
    endfunction

    always @(posedge clk) cyc++;

    // engine model: answers each poll read on the following cycle from poll_q
    always begin
        @(posedge clk);
        #1;
        aes_resp_valid = 1'b0;
        aes_resp_data  = '0;
        if (!rst && reads_seen > served && poll_q.size() > 0) begin
            aes_resp_valid = 1'b1;
            aes_resp_data  = poll_q.pop_front();
            served++;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (aes_req_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got wr=%0d addr=0x%0h data=0x%0h expected none (cycle %0d)",
                             aes_req_isWrite, aes_req_addr, aes_req_data, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("req_type", 64'(aes_req_isWrite), 64'(mon_e.wr));
                    chk("req_addr", 64'(aes_req_addr), 64'(mon_e.addr));
                    chk("req_data", aes_req_data, mon_e.data);
                    if (mon_e.consec) chk("req_spacing", 64'(cyc - prev_req_cyc), 64'd1);
                end
                if (!aes_req_isWrite) begin
                    reads_seen++;
                    if (nz_pend) begin
                        chk("poll_gap", 64'(cyc - nz_cyc), 64'(POLL_GAP + 1));
                        nz_pend = 1'b0;
                    end
                end
                prev_req_cyc = cyc;
            end
            if (aes_resp_valid) begin
                resp_seen = 1'b1;
                if (aes_resp_data != 64'h0) begin
                    nz_pend = 1'b1;
                    nz_cyc  = cyc;
                end
            end
            if (host_resp_valid) begin
                if (hexp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_host_resp: got 0x%0h expected none", host_resp_data);
                end else begin
                    chk("host_resp", host_resp_data, hexp_q.pop_front());
                end
            end
            if (job_done) done_pulses++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [6:0] a, input logic [63:0] d);
        host_req_valid = 1'b1; host_req_isWrite = 1'b1;
        host_req_addr = {25'h0, a}; host_req_data = d;
        tick(1);
        host_req_valid = 1'b0; host_req_isWrite = 1'b0;
    endtask

    task automatic host_read(input logic [6:0] a, input logic [63:0] expv);
        hexp_q.push_back(expv);
        host_req_valid = 1'b1; host_req_isWrite = 1'b0;
        host_req_addr = {25'h0, a}; host_req_data = '0;
        tick(1);
        host_req_valid = 1'b0;
    endtask

    task automatic push_job(input logic [255:0] k, input logic [63:0] s, input logic [63:0] d, input logic [33:0] w);
        host_write(7'h00, k[63:0]);
        host_write(7'h08, k[127:64]);
        host_write(7'h10, k[191:128]);
        host_write(7'h18, k[255:192]);
        host_write(7'h20, s);
        host_write(7'h28, d);
        host_write(7'h30, {30'h0, w});
    endtask

    task automatic expect_job(input logic [255:0] k, input logic [63:0] s, input logic [63:0] d, input logic [33:0] w);
        exp_q.push_back(mk(1'b1, 32'h00, k[63:0], 1'b0));
        exp_q.push_back(mk(1'b1, 32'h08, k[127:64], 1'b1));
        exp_q.push_back(mk(1'b1, 32'h10, k[191:128], 1'b1));
        exp_q.push_back(mk(1'b1, 32'h18, k[255:192], 1'b1));
        exp_q.push_back(mk(1'b1, 32'h20, s, 1'b1));
        exp_q.push_back(mk(1'b1, 32'h28, d, 1'b1));
        exp_q.push_back(mk(1'b1, 32'h38, 64'd8, 1'b1));
        exp_q.push_back(mk(1'b1, 32'h40, 64'd8, 1'b1));
        exp_q.push_back(mk(1'b1, 32'h30, {30'h0, w}, 1'b1));
        exp_q.push_back(mk(1'b0, 32'h00, 64'h0, 1'b1));
    endtask

    task automatic wait_idle(input int target, input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || done_pulses < target) && n < 2000) begin
            tick(1);
            n++;
        end
        chk({name, "_drain"}, 64'(exp_q.size()), 64'd0);
        chk({name, "_done_pulses"}, 64'(done_pulses), 64'(target));
        tick(3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // reset values
        tick(2);
        chk("rst_aes_req_valid", 64'(aes_req_valid), 64'd0);
        chk("rst_aes_req_addr", 64'(aes_req_addr), 64'd0);
        chk("rst_host_resp_valid", 64'(host_resp_valid), 64'd0);
        chk("rst_job_done", 64'(job_done), 64'd0);
        rst = 1'b0;
        tick(2);
        host_read(7'h38, 64'h0);
        host_read(7'h20, 64'h0);
        tick(2);

        // single job: poll 64 then 0
        poll_q.push_back(64'd64);
        poll_q.push_back(64'd0);
        expect_job(mkkey(8'h01), 64'h1000, 64'h8000, 34'd128);
        exp_q.push_back(mk(1'b0, 32'h00, 64'h0, 1'b0));
        push_job(mkkey(8'h01), 64'h1000, 64'h8000, 34'd128);
        wait_idle(1, "single");
        host_read(7'h38, 64'h0000_0001_0000_0000);
        tick(2);

        // poll spacing after a response of 5
        poll_q.push_back(64'd5);
        poll_q.push_back(64'd0);
        expect_job(mkkey(8'h02), 64'h2000, 64'h9000, 34'd5);
        exp_q.push_back(mk(1'b0, 32'h00, 64'h0, 1'b0));
        push_job(mkkey(8'h02), 64'h2000, 64'h9000, 34'd5);
        wait_idle(2, "spacing");

        // overflow: A stalls in POLL_RSP, B..E fill the queue, F is dropped
        expect_job(mkkey(8'hA0), 64'hA000, 64'hA800, 34'd16);
        push_job(mkkey(8'hA0), 64'hA000, 64'hA800, 34'd16);
        for (int j = 1; j <= 5; j++) begin
            push_job(mkkey(8'hA0 + 8'(j)), 64'hA000 + 64'(j), 64'hA800 + 64'(j), 34'(j));
        end
        tick(3);
        host_read(7'h38, 64'h0000_0002_0000_0403);
        tick(2);
        for (int j = 1; j <= 4; j++) begin
            expect_job(mkkey(8'hA0 + 8'(j)), 64'hA000 + 64'(j), 64'hA800 + 64'(j), 34'(j));
        end
        for (int j = 0; j < 5; j++) poll_q.push_back(64'd0);
        wait_idle(7, "overflow");
        host_read(7'h38, 64'h0000_0007_0000_0002);
        tick(2);

        // back-to-back, each completing on the first poll (one with words=0)
        for (int j = 0; j < 3; j++) poll_q.push_back(64'd0);
        expect_job(mkkey(8'hB1), 64'hB100, 64'hC100, 34'h10);
        expect_job(mkkey(8'hB2), 64'hB200, 64'hC200, 34'h0);
        expect_job(mkkey(8'hB3), 64'hB300, 64'hC300, 34'h3_FFFF_FFFF);
        push_job(mkkey(8'hB1), 64'hB100, 64'hC100, 34'h10);
        push_job(mkkey(8'hB2), 64'hB200, 64'hC200, 34'h0);
        push_job(mkkey(8'hB3), 64'hB300, 64'hC300, 34'h3_FFFF_FFFF);
        wait_idle(10, "b2b");
        host_read(7'h38, 64'h0000_000A_0000_0002);
        tick(2);

        // abort during GAP with two jobs queued
        expect_job(mkkey(8'hD0), 64'hD000, 64'hD800, 34'd99);
        push_job(mkkey(8'hD0), 64'hD000, 64'hD800, 34'd99);
        push_job(mkkey(8'hD1), 64'hD001, 64'hD801, 34'd1);
        push_job(mkkey(8'hD2), 64'hD002, 64'hD802, 34'd2);
        tick(2);
        host_read(7'h38, 64'h0000_000A_0000_0203);
        tick(2);
        resp_seen = 1'b0;
        poll_q.push_back(64'd9);
        n = 0;
        while (!resp_seen && n < 50) begin
            tick(1);
            n++;
        end
        chk("abort_resp_seen", 64'(resp_seen), 64'd1);
        tick(3);
        exp_q.push_back(mk(1'b1, 32'h30, 64'h0, 1'b0));
        host_write(7'h40, 64'h0);
        nz_pend = 1'b0;
        tick(30);
        wait_idle(10, "abort");
        host_read(7'h38, 64'h0000_000A_0000_0002);
        tick(2);

        // reset while PROG is at idx 4
        exp_q.push_back(mk(1'b1, 32'h00, mkkey(8'hE0) >> 0, 1'b0));
        exp_q[$].data = 64'hC0DE_0001_0000_00E0;
        exp_q.push_back(mk(1'b1, 32'h08, 64'hC0DE_0002_0000_00E0, 1'b1));
        exp_q.push_back(mk(1'b1, 32'h10, 64'hC0DE_0003_0000_00E0, 1'b1));
        exp_q.push_back(mk(1'b1, 32'h18, 64'hC0DE_0004_0000_00E0, 1'b1));
        push_job(mkkey(8'hE0), 64'hE000, 64'hE800, 34'd7);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(aes_req_valid && aes_req_addr == 32'h18) && n < 100);
        chk("reset_point_found", 64'(n < 100), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_prog_valid", 64'(aes_req_valid), 64'd0);
        chk("rst_mid_prog_exp", 64'(exp_q.size()), 64'd0);
        tick(2);
        rst = 1'b0;
        tick(2);
        host_read(7'h38, 64'h0);
        tick(25);
        chk("post_reset_quiet", 64'(exp_q.size()), 64'd0);

        tick(3);
        chk("host_resp_drain", 64'(hexp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_job_sched.md
Name: aes_job_sched

Overview:
- Job scheduler in front of the AES-CTR stream engine.
- Host software enqueues complete AES jobs (key, source address, destination address, word count) into a descriptor queue through a host-side soft-register port.
- The block programs the engine's soft-register interface one job at a time, polls for completion, and counts finished jobs.
- It sits between the shell soft-register path and the engine, so jobs run back-to-back without host round trips.

Parameters:
- LOG_DEPTH, 2: log2 of the descriptor queue depth (4 jobs).
- CREDITS, 8: value written to the engine's read-credit and write-credit registers for every job.
- POLL_GAP, 16: idle cycles between a nonzero poll response and the next poll read.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- host_req_valid  in  1  host soft-register request strobe
- host_req_isWrite  in  1  1 = write, 0 = read
- host_req_addr  in  32  host register byte address
- host_req_data  in  64  host write data
- host_resp_valid  out  1  read response strobe
- host_resp_data  out  64  read response data
- aes_req_valid  out  1  engine soft-register request strobe
- aes_req_isWrite  out  1  engine request type
- aes_req_addr  out  32  engine register address
- aes_req_data  out  64  engine write data
- aes_resp_valid  in  1  engine read response strobe
- aes_resp_data  in  64  engine read data; remaining output words
- job_done  out  1  one-cycle pulse per completed job

Behaviour:
- Reset (async, active-high): all outputs 0; FSM to IDLE; queue empty; staging registers, done_count and overflow cleared.
- Host writes, decoded on addr[6:0]:
  - 0x00/0x08/0x10/0x18: key[63:0] / key[127:64] / key[191:128] / key[255:192] staging.
  - 0x20: src staging. 0x28: dst staging.
  - 0x30: words = data[33:0]; same cycle, pushes {key, src, dst, words} into the queue.
  - 0x40: abort.
  - Other addresses: ignored.
- Push when the pre-cycle count == depth: dropped, overflow sticky set. A pop in the same cycle does not make room.
- Host reads: response 1 cycle later.
  - addr 0x38 returns status: [0] busy (FSM != IDLE), [1] overflow, [15:8] queue count, [63:32] done_count.
  - Any other address returns 0.
  - Host writes produce no response.
- Engine port: at most one request per cycle. aes_req_valid is a 1-cycle strobe, registered.
- FSM states:
  - IDLE: if the queue is non-empty, pop the head into the active descriptor and go to PROG at idx=0.
  - PROG: one write per cycle, idx 0..8, to addr 0x00, 0x08, 0x10, 0x18 (key quarters), 0x20 (src), 0x28 (dst), 0x38 (CREDITS), 0x40 (CREDITS), 0x30 (words). The words write is always last, because it starts the engine. After idx 8 go to POLL_REQ.
  - POLL_REQ: issue one read (isWrite=0, addr 0x00), go to POLL_RSP.
  - POLL_RSP: wait for aes_resp_valid. Data == 0: pulse job_done, done_count+1 (32-bit, wraps), go to IDLE. Data != 0: go to GAP.
  - GAP: count POLL_GAP cycles, then go to POLL_REQ.
  - ABORT: issue write addr 0x30 data 0, then go to IDLE.
- Poll timing: the earliest poll read is the cycle after the words write, which observes the updated word count. A words=0 job completes on the first poll.
- Abort:
  - Flushes the queue (count→0) in the write cycle.
  - IDLE: no engine traffic.
  - PROG: the write in flight this cycle completes, then go to ABORT.
  - POLL_REQ/GAP: go to ABORT next cycle.
  - POLL_RSP: a response arriving in the abort cycle is ignored; go to ABORT.
  - An aborted job does not increment done_count or pulse job_done.
- A push in the same cycle as abort: the flush wins and the push is discarded.
- A pop and a push in the same cycle with count < depth: both occur; count unchanged.
- Pointers wrap modulo depth; count is LOG_DEPTH+1 bits.

Test Plan:
- Single job (key=0x11..44, src=0x1000, dst=0x8000, words=128): nine writes on consecutive cycles in the specified order, addr 0x30 data 128 last. Poll responses 64, then 0 → one job_done pulse; status done_count=1, busy=0.
- Poll spacing: response 5 → next poll read exactly POLL_GAP+1 cycles after the response strobe.
- Queue overflow: 5 pushes while the first job is stalled in POLL_RSP → queue count 4, overflow=1, the 5th descriptor is never programmed.
- Back-to-back: 3 queued jobs, each completing on its first poll → 3 distinct PROG sequences with the correct per-job src/dst/words; done_count=3.
- Abort during GAP with 2 jobs queued → next engine request is write 0x30 data 0; FSM returns to IDLE; count=0; done_count unchanged.
- Reset asserted mid-PROG (idx 4) → aes_req_valid drops immediately; after deassert, status reads 0 and no engine request is issued.
